// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: FSM, move tick, direction queue, score and length
// Optional speed-up (period shrinks with score) enabled by defining SNAKE_CTRL_SPEEDUP_EN.

module snake_game_ctrl #(
   parameter int unsigned TICK_PERIOD = 50000,
   parameter int unsigned MAX_LENGTH  = 64,
   parameter int unsigned SCORE_W     = 7,
   parameter int unsigned MIN_PERIOD  = 10000,
   parameter int unsigned SPEED_STEP  = 2000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               goodColl_p,
   input  logic               badColl_p,
   input  logic               button_p,
   input  logic [3:0]         direction_p,
   output logic [1:0]         state,
   output logic               move_strb,
   output logic [3:0]         dir,
   output logic [6:0]         length,
   output logic [SCORE_W-1:0] score,
   output logic               grow,
   output logic               clr,
   output logic               game_over
);
   localparam int unsigned CNT_W   = $clog2(TICK_PERIOD);
   localparam logic [3:0]  DIR_R   = 4'b0001;
   localparam logic [6:0]  LEN_INI = 7'd3;
   localparam logic [6:0]  LEN_MAX = 7'(MAX_LENGTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3} state_t;

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n, per_last;
   logic [3:0]           dir_n, q0_q, q0_n, q1_q, q1_n, tail;
   logic [1:0]           qcnt_q, qcnt_n;
   logic [6:0]           len_n;
   logic [SCORE_W-1:0]   score_n;
   logic                 strb_n, grow_n, clr_n, wrap, pop, press_ok;

   function automatic logic [3:0] opposite(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   function automatic logic one_hot(input logic [3:0] d);
      return (d != 4'b0) && ((d & (d - 4'd1)) == 4'b0);
   endfunction

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      dir_n    = dir;
      len_n    = length;
      score_n  = score;
      q0_n     = q0_q;
      q1_n     = q1_q;
      qcnt_n   = qcnt_q;
      strb_n   = 1'b0;
      grow_n   = 1'b0;
      clr_n    = 1'b0;
      wrap     = 1'b0;
      pop      = 1'b0;
      press_ok = 1'b0;
      // Presses are judged against the newest pending heading, pre-pop
      tail = (qcnt_q == 2'd2) ? q1_q : (qcnt_q == 2'd1) ? q0_q : dir;
      case (state_q)
         S_IDLE: begin
            if (button_p) begin
               state_n = S_RUN;
               clr_n   = 1'b1;
               score_n = '0;
               len_n   = LEN_INI;
               dir_n   = DIR_R;
               cnt_n   = '0;
               qcnt_n  = '0;
            end
         end
         S_RUN: begin
            if (badColl_p) begin
               state_n = S_OVER;
               qcnt_n  = '0;
            end else begin
               if (goodColl_p) begin
                  grow_n = 1'b1;
                  if (score != '1) score_n = score + SCORE_W'(1);
                  if (length < LEN_MAX) len_n = length + 7'd1;
               end else if (button_p) begin
                  state_n = S_PAUSE;
               end
               if (state_n == S_RUN) begin
                  if (cnt_q == per_last) begin
                     cnt_n  = '0;
                     wrap   = 1'b1;
                     strb_n = 1'b1;
                  end else begin
                     cnt_n = cnt_q + CNT_W'(1);
                  end
               end
               pop      = wrap && (qcnt_q != 2'd0);
               press_ok = one_hot(direction_p) && (qcnt_q != 2'd2) &&
                          (direction_p != tail) && (direction_p != opposite(tail));
               if (pop) begin
                  dir_n  = q0_q;
                  q0_n   = q1_q;
                  qcnt_n = qcnt_q - 2'd1;
               end
               if (press_ok) begin
                  if (qcnt_n == 2'd0) q0_n = direction_p;
                  else                q1_n = direction_p;
                  qcnt_n = qcnt_n + 2'd1;
               end
            end
         end
         S_PAUSE: if (button_p) state_n = S_RUN;
         S_OVER:  if (button_p) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dir       <= DIR_R;
         length    <= LEN_INI;
         score     <= '0;
         move_strb <= 1'b0;
         grow      <= 1'b0;
         clr       <= 1'b0;
         game_over <= 1'b0;
         q0_q      <= '0;
         q1_q      <= '0;
         qcnt_q    <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         dir       <= dir_n;
         length    <= len_n;
         score     <= score_n;
         move_strb <= strb_n;
         grow      <= grow_n;
         clr       <= clr_n;
         game_over <= (state_n == S_OVER);
         q0_q      <= q0_n;
         q1_q      <= q1_n;
         qcnt_q    <= qcnt_n;
      end
   end

   assign state = state_q;

`ifdef SNAKE_CTRL_SPEEDUP_EN
   logic [CNT_W-1:0] per_last_q, per_next_q;
   logic [31:0]      red, per_calc;

   always_comb begin
      red      = 32'(score) * SPEED_STEP;
      per_calc = (TICK_PERIOD > MIN_PERIOD + red) ? TICK_PERIOD - red : MIN_PERIOD;
   end

   // Newly computed period is only adopted at a wrap so a step never shortens midway
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_last_q <= CNT_W'(TICK_PERIOD - 1);
         per_next_q <= CNT_W'(TICK_PERIOD - 1);
      end else begin
         per_next_q <= CNT_W'(per_calc - 32'd1);
         if (clr_n)     per_last_q <= CNT_W'(TICK_PERIOD - 1);
         else if (wrap) per_last_q <= per_next_q;
      end
   end

   assign per_last = per_last_q;
`else
   logic unused_speed_params;
   assign unused_speed_params = ^{MIN_PERIOD, SPEED_STEP};
   assign per_last = CNT_W'(TICK_PERIOD - 1);
`endif

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - table-driven self-checking bench for snake_game_ctrl

module tb_snake_game_ctrl;
   localparam int TP = 4;
   localparam int ML = 6;
   localparam int SW = 3;
   localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001, Z = 4'b0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          goodColl_p = 1'b0, badColl_p = 1'b0, button_p = 1'b0;
   logic [3:0]    direction_p = 4'b0;
   logic [1:0]    state;
   logic          move_strb, grow, clr, game_over;
   logic [3:0]    dir;
   logic [6:0]    length;
   logic [SW-1:0] score;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          btn, good, bad;
      logic [3:0]    dp;
      logic [1:0]    st;
      logic          strb;
      logic [3:0]    dir;
      logic [6:0]    len;
      logic [SW-1:0] sc;
      logic          grow, clr, go;
   } vec_t;

   vec_t tab[$];

   always #5 clk = ~clk;

   snake_game_ctrl #(.TICK_PERIOD(TP), .MAX_LENGTH(ML), .SCORE_W(SW)) dut (
      .clk(clk), .rst(rst), .goodColl_p(goodColl_p), .badColl_p(badColl_p),
      .button_p(button_p), .direction_p(direction_p), .state(state),
      .move_strb(move_strb), .dir(dir), .length(length), .score(score),
      .grow(grow), .clr(clr), .game_over(game_over)
   );

   function automatic vec_t mk(logic btn, logic good, logic bad, logic [3:0] dp, logic [1:0] st,
                               logic strb, logic [3:0] d, logic [6:0] len, logic [SW-1:0] sc,
                               logic gr, logic cl, logic go);
      vec_t v;
      v.btn = btn; v.good = good; v.bad = bad; v.dp = dp; v.st = st; v.strb = strb;
      v.dir = d; v.len = len; v.sc = sc; v.grow = gr; v.clr = cl; v.go = go;
      return v;
   endfunction

   task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s actual=%0h required=%0h", tag, fld, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input vec_t v);
      cmp(tag, "state", 32'(state), 32'(v.st));
      cmp(tag, "move_strb", 32'(move_strb), 32'(v.strb));
      cmp(tag, "dir", 32'(dir), 32'(v.dir));
      cmp(tag, "length", 32'(length), 32'(v.len));
      cmp(tag, "score", 32'(score), 32'(v.sc));
      cmp(tag, "grow", 32'(grow), 32'(v.grow));
      cmp(tag, "clr", 32'(clr), 32'(v.clr));
      cmp(tag, "game_over", 32'(game_over), 32'(v.go));
   endtask

   task automatic step(input string tag, input vec_t v);
      @(negedge clk);
      button_p = v.btn; goodColl_p = v.good; badColl_p = v.bad; direction_p = v.dp;
      @(posedge clk);
      #1;
      check_out(tag, v);
      button_p = 1'b0; goodColl_p = 1'b0; badColl_p = 1'b0; direction_p = 4'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) step($sformatf("row%0d", i), tab[i]);
   endtask

   initial begin
      int a_end, b_end, c_end;
      vec_t rstv;
      rstv = mk(0, 0, 0, Z, 0, 0, R, 3, 0, 0, 0, 0);

      // start, cadence, queue, reversal, scoring, pause entry
      tab.push_back(mk(1, 0, 0, Z, 1, 0, R, 3, 0, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, L, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, U, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, L, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, D, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, R, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 4'b0011, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, L, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, U, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, L, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, D, 1, 1, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, U, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, U, 4, 1, 1, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 4, 1, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, U, 5, 2, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 1, U, 6, 3, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, U, 6, 4, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, U, 6, 5, 1, 0, 0));
      tab.push_back(mk(1, 0, 0, Z, 2, 0, U, 6, 5, 0, 0, 0));
      a_end = tab.size();
      // resume, game over, restart, score saturation, priorities, setup for reset
      tab.push_back(mk(1, 0, 0, Z, 1, 0, U, 6, 5, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, U, 6, 5, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, U, 6, 5, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, Z, 3, 0, U, 6, 5, 0, 0, 1));
      tab.push_back(mk(0, 0, 0, Z, 3, 0, U, 6, 5, 0, 0, 1));
      tab.push_back(mk(0, 1, 0, L, 3, 0, U, 6, 5, 0, 0, 1));
      tab.push_back(mk(1, 0, 0, Z, 0, 0, U, 6, 5, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 0, 0, U, 6, 5, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, Z, 1, 0, R, 3, 0, 0, 1, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 4, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 5, 2, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 3, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 1, R, 6, 4, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 5, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 6, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 7, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 1, R, 6, 7, 1, 0, 0));
      tab.push_back(mk(1, 1, 0, Z, 1, 0, R, 6, 7, 1, 0, 0));
      tab.push_back(mk(1, 0, 1, Z, 3, 0, R, 6, 7, 0, 0, 1));
      tab.push_back(mk(1, 0, 0, Z, 0, 0, R, 6, 7, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, Z, 1, 0, R, 3, 0, 0, 1, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 4, 1, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 5, 2, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 3, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 1, R, 6, 4, 1, 0, 0));
      tab.push_back(mk(0, 1, 0, Z, 1, 0, R, 6, 5, 1, 0, 0));
      tab.push_back(mk(0, 0, 0, U, 1, 0, R, 6, 5, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, L, 1, 0, R, 6, 5, 0, 0, 0));
      b_end = tab.size();
      // after reset: idle, then a fresh start must strobe right (queue was flushed)
      for (int k = 0; k < 10; k++) tab.push_back(rstv);
      tab.push_back(mk(1, 0, 0, Z, 1, 0, R, 3, 0, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 0, R, 3, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, Z, 1, 1, R, 3, 0, 0, 0, 0));
      c_end = tab.size();

      @(negedge clk);
      check_out("reset", rstv);
      @(negedge clk);
      rst = 1'b0;

      run_rows(0, a_end);
      for (int k = 0; k < 20; k++)
         step($sformatf("pause%0d", k),
              mk(0, k == 5, k == 10, (k == 15) ? L : Z, 2, 0, U, 6, 5, 0, 0, 0));
      run_rows(a_end, b_end);

      #2;
      rst = 1'b1;
      #1;
      check_out("async_rst", rstv);
      repeat (2) @(posedge clk);
      #1;
      check_out("held_rst", rstv);
      @(negedge clk);
      rst = 1'b0;
      run_rows(b_end, c_end);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Central game sequencer for the snake game.
- Consumes single-cycle edge pulses from the input edge detector: good collision, bad collision, button and direction.
- Runs the game state machine and generates the periodic move strobe for the snake datapath.
- Buffers direction presses, rejects reversals, and maintains score and snake length.

Parameters:
- TICK_PERIOD, 50000, clocks per move step at base speed (must be >= 2).
- MAX_LENGTH, 64, saturation limit for length.
- SCORE_W, 7, score width.
- MIN_PERIOD, 10000, floor on move period (SPEEDUP_EN only).
- SPEED_STEP, 2000, period reduction per point scored (SPEEDUP_EN only).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- goodColl_p  input  1  food-eaten pulse, 1 cycle
- badColl_p  input  1  wall/self collision pulse, 1 cycle
- button_p  input  1  start/pause button pulse, 1 cycle
- direction_p  input  4  direction press pulse, one-hot: [3]=up, [2]=down, [1]=left, [0]=right
- state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
- move_strb  output  1  advance snake one cell, 1 cycle
- dir  output  4  current heading, one-hot; valid whenever move_strb is high
- length  output  7  snake length in cells
- score  output  SCORE_W  points scored
- grow  output  1  1-cycle pulse: extend tail on next move
- clr  output  1  1-cycle pulse: clear board on game start
- game_over  output  1  level, high while in OVER

Behaviour:
- Reset: asynchronous and immediate.
  - Outputs: state=IDLE, dir=4'b0001, length=3, score=0.
  - move_strb, grow, clr and game_over = 0.
  - Tick counter = 0; direction queue empty.
- All outputs are registered.
- IDLE:
  - button_p -> RUN.
  - On that edge: clr=1 for 1 cycle; score=0, length=3, dir=right; counter=0; queue cleared.
- RUN, tick counter:
  - Counts 0..P-1, where P is the active period.
  - When counter==P-1: counter wraps to 0. On the same edge, move_strb=1 for the next cycle. If the queue is non-empty, the head pops into dir on that same edge, so the new dir is valid with the strobe.
  - First strobe appears P cycles after entering RUN.
- RUN, direction queue:
  - 2-entry FIFO.
  - direction_p that is not exactly one-hot (zero or multi-bit) is ignored.
  - A press is compared against the queue tail, or against dir if the queue is empty. Equal or opposite direction -> dropped.
  - Press with queue full -> dropped.
  - Push and pop in the same cycle: both occur. The comparison uses the pre-pop tail.
- RUN, collisions and button:
  - goodColl_p: score+1 (saturating at 2^SCORE_W-1); length+1 (saturating at MAX_LENGTH); grow=1 for the next cycle. grow still pulses when length is saturated.
  - badColl_p -> OVER; game_over=1; queue cleared.
  - Priority when events coincide: badColl_p > goodColl_p > button_p. goodColl_p together with badColl_p leaves score and length unchanged.
  - button_p (no collision) -> PAUSE.
- PAUSE:
  - Counter frozen; no move_strb.
  - Direction presses and collisions ignored; queue contents retained.
  - button_p -> RUN; counting resumes from the frozen value.
- OVER:
  - game_over held high; score and length held; all inputs except button_p ignored.
  - button_p -> IDLE; game_over drops on the same edge.
  - Score and length remain visible in IDLE until the next start.
- Input pulses arriving in any other state are ignored.
- rst asserted mid-game returns everything to reset values with no further strobes.

Optional Feature:
- Macro SNAKE_CTRL_SPEEDUP_EN.
- Defined:
  - P = max(MIN_PERIOD, TICK_PERIOD - score*SPEED_STEP), computed in a registered stage.
  - A new P takes effect only at the next counter wrap; the current step always completes at the old period.
  - P resets to TICK_PERIOD on game start.
- Undefined: P = TICK_PERIOD constant; MIN_PERIOD and SPEED_STEP unused.

Test Plan:
All scenarios use TICK_PERIOD=4.
1. Start and strobe cadence: release rst, button_p -> state=1, clr high exactly 1 cycle, move_strb every 4th cycle with dir=0001, length=3, score=0.
2. Queue and reversal: in RUN with dir=right, pulse up then left on consecutive cycles -> next strobe dir=1000, following strobe dir=0010. A left pulse while dir=right and the queue is empty -> dropped, dir stays 0001.
3. Scoring and saturation: three goodColl_p pulses -> score=3, length=6, three grow pulses. With MAX_LENGTH=4, length holds at 4 while score keeps incrementing.
4. Pause: button_p in RUN -> state=2, no move_strb for 20 cycles. button_p again -> first strobe arrives after the remaining frozen count, not a full period.
5. Game over: goodColl_p and badColl_p in the same cycle -> state=3, game_over=1, score unchanged. button_p -> state=0, game_over=0, score still shown.
6. Reset mid-game: assert rst mid-RUN with score=5 and the queue holding 2 entries -> outputs reset asynchronously with no clock edge needed; after release, no strobe until the next button_p.
